// File: rtl/updown_sweep_ctrl_if.sv
// updown_sweep_ctrl_if: command handshake and count-status bundle for the
// up/down sweep controller.
//   master : command source (drives cmd_*, abort; observes status)
//   slave  : the controller (accepts cmd_*, abort; drives cmd_ready, q,
//            updown, busy, done)
interface updown_sweep_ctrl_if #(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [WIDTH-1:0]  cmd_target;
  logic              cmd_bounce;
  logic [PASS_W-1:0] cmd_passes;
  logic              abort;
  logic [WIDTH-1:0]  q;
  logic              updown;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_target, cmd_bounce, cmd_passes, abort,
    input  cmd_ready, q, updown, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_bounce, cmd_passes, abort,
    output cmd_ready, q, updown, busy, done
  );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: command-driven sequencer owning a count register q.
// A command either moves q one step per clock to a target (GOTO) or sweeps
// between the origin and the target for a number of legs (BOUNCE).
// Ports:
//   clk      clock, all state updates on posedge
//   clear_n  asynchronous active-low reset
//   bus      updown_sweep_ctrl_if.slave (command handshake, abort, status)
module updown_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int PASS_W = 4
) (
  input logic                clk,
  input logic                clear_n,
  updown_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]  Q_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0]  Q_ZERO   = WIDTH'(0);
  localparam logic [PASS_W-1:0] LEG_ONE  = PASS_W'(1);
  localparam logic [PASS_W-1:0] LEG_ZERO = PASS_W'(0);

  state_t            state_r, state_s;
  logic [WIDTH-1:0]  q_r, q_s;
  logic              updown_r, updown_s;
  logic [WIDTH-1:0]  target_r, target_s;
  logic [WIDTH-1:0]  origin_r, origin_s;
  logic              to_target_r, to_target_s;  // current leg heads to target
  logic              bounce_r, bounce_s;
  logic [PASS_W-1:0] legs_r, legs_s;
  logic              busy_r, done_r, ready_r;

  logic [WIDTH-1:0]  step_s;
  logic [WIDTH-1:0]  endpoint_s;
  logic              last_leg_s;

  // Next-state, next-count and command-latch logic.
  always_comb begin
    state_s     = state_r;
    q_s         = q_r;
    updown_s    = updown_r;
    target_s    = target_r;
    origin_s    = origin_r;
    to_target_s = to_target_r;
    bounce_s    = bounce_r;
    legs_s      = legs_r;
    step_s      = updown_r ? (q_r + Q_ONE) : (q_r - Q_ONE);
    endpoint_s  = to_target_r ? target_r : origin_r;
    last_leg_s  = (!bounce_r) || (legs_r == LEG_ONE);

    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          target_s    = bus.cmd_target;
          origin_s    = q_r;
          bounce_s    = bus.cmd_bounce;
          legs_s      = (bus.cmd_passes == LEG_ZERO) ? LEG_ONE : bus.cmd_passes;
          to_target_s = 1'b1;
          if (bus.cmd_target == q_r) begin
            state_s = ST_DONE;
          end else begin
            state_s  = ST_RUN;
            updown_s = (bus.cmd_target > q_r);
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // The final step always completes, even if abort arrives with it.
        if ((step_s == endpoint_s) && last_leg_s) begin
          q_s     = step_s;
          state_s = ST_DONE;
          legs_s  = bounce_r ? (legs_r - LEG_ONE) : legs_r;
        end else if (bus.abort) begin
          state_s = ST_DONE;
        end else begin
          q_s = step_s;
          if (step_s == endpoint_s) begin
            // Turnaround: no dwell, the reversed step happens next edge.
            legs_s      = legs_r - LEG_ONE;
            updown_s    = !updown_r;
            to_target_s = !to_target_r;
          end else begin
            legs_s = legs_r;
          end
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, count and latched-command registers; status flags are registered
  // decodes of the next state so they change cleanly with the state.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_r     <= ST_IDLE;
      q_r         <= Q_ZERO;
      updown_r    <= 1'b1;
      target_r    <= Q_ZERO;
      origin_r    <= Q_ZERO;
      to_target_r <= 1'b1;
      bounce_r    <= 1'b0;
      legs_r      <= LEG_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      state_r     <= state_s;
      q_r         <= q_s;
      updown_r    <= updown_s;
      target_r    <= target_s;
      origin_r    <= origin_s;
      to_target_r <= to_target_s;
      bounce_r    <= bounce_s;
      legs_r      <= legs_s;
      busy_r      <= (state_s == ST_RUN);
      done_r      <= (state_s == ST_DONE);
      ready_r     <= (state_s == ST_IDLE);
    end
  end

  assign bus.q         = q_r;
  assign bus.updown    = updown_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.cmd_ready = ready_r;
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
module tb_updown_sweep_ctrl;
  logic clk;
  logic clear_n;

  updown_sweep_ctrl_if #(.WIDTH(4), .PASS_W(4)) bus ();

  updown_sweep_ctrl #(.WIDTH(4), .PASS_W(4)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: remaining trajectory of q as a queue of future values.
  int m_q;
  int m_ud;
  int m_done;
  int m_acc;
  int m_path[$];

  task automatic tb_check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0;
    m_ud = 1;
    m_done = 0;
    m_acc = 0;
    m_path.delete();
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    int t;
    int o;
    int e;
    int cur;
    int legs;
    m_acc = 0;
    if (m_done != 0) begin
      m_done = 0;
    end else if (m_path.size() > 0) begin
      if (m_path.size() == 1 || bus.abort == 1'b0) begin
        m_q = m_path.pop_front();
        if (m_path.size() > 0) m_ud = (m_path[0] > m_q) ? 1 : 0;
        else m_done = 1;
      end else begin
        m_path.delete();
        m_done = 1;
      end
    end else if (bus.cmd_valid == 1'b1) begin
      m_acc = 1;
      t = int'(bus.cmd_target);
      if (t == m_q) begin
        m_done = 1;
      end else begin
        legs = (bus.cmd_passes == 4'd0) ? 1 : int'(bus.cmd_passes);
        if (bus.cmd_bounce == 1'b0) legs = 1;
        o = m_q;
        cur = m_q;
        e = t;
        for (int l = 0; l < legs; l++) begin
          while (cur != e) begin
            cur = (e > cur) ? cur + 1 : cur - 1;
            m_path.push_back(cur);
          end
          e = (e == t) ? o : t;
        end
        m_ud = (t > m_q) ? 1 : 0;
      end
    end
  endtask

  task automatic compare_all();
    tb_check("q", int'(bus.q), m_q);
    tb_check("updown", int'(bus.updown), m_ud);
    tb_check("busy", int'(bus.busy), (m_path.size() > 0) ? 1 : 0);
    tb_check("done", int'(bus.done), m_done);
    tb_check("cmd_ready", int'(bus.cmd_ready), (m_path.size() == 0 && m_done == 0) ? 1 : 0);
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drain(input int abort_q);
    int n;
    n = 0;
    while ((m_path.size() > 0 || m_done != 0) && n < 200) begin
      bus.abort = (m_path.size() > 0 && m_q == abort_q) ? 1'b1 : 1'b0;
      step_cycle();
      bus.abort = 1'b0;
      n++;
    end
    if (n >= 200) tb_check("drain_timeout", 0, 1);
  endtask

  task automatic issue(input int t, input int b, input int p, input int abort_q);
    int n;
    bus.cmd_target = 4'(t);
    bus.cmd_bounce = b[0];
    bus.cmd_passes = 4'(p);
    bus.cmd_valid  = 1'b1;
    n = 0;
    do begin
      step_cycle();
      n++;
    end while (m_acc == 0 && n < 200);
    if (n >= 200) tb_check("accept_timeout", 0, 1);
    bus.cmd_valid = 1'b0;
    drain(abort_q);
  endtask

  initial begin
    int n;
    checks = 0;
    failures = 0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_target = 4'd0;
    bus.cmd_bounce = 1'b0;
    bus.cmd_passes = 4'd0;
    bus.abort      = 1'b0;
    model_reset();

    // Reset held over several edges, released mid-cycle.
    clear_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear_n = 1'b1;
    #1;
    compare_all();
    step_cycle();

    // GOTO up to 9, then down to 3.
    issue(9, 0, 1, -1);
    tb_check("goto9_final", int'(bus.q), 9);
    issue(3, 0, 1, -1);
    tb_check("goto3_final", int'(bus.q), 3);

    // Zero distance, GOTO and BOUNCE.
    issue(3, 0, 1, -1);
    issue(3, 1, 2, -1);

    // BOUNCE 2 <-> 5 for 3 legs, then passes = 0 acts as one leg.
    issue(2, 0, 1, -1);
    issue(5, 1, 3, -1);
    tb_check("bounce3_final", int'(bus.q), 5);
    issue(2, 0, 1, -1);
    issue(5, 1, 0, -1);
    tb_check("bounce0_final", int'(bus.q), 5);
    issue(2, 0, 1, -1);
    issue(5, 1, 2, -1);
    tb_check("bounce2_final", int'(bus.q), 2);

    // Abort mid-move at 7, and abort coinciding with the final step.
    issue(0, 0, 1, -1);
    issue(15, 0, 1, 7);
    tb_check("abort_hold", int'(bus.q), 7);
    issue(0, 0, 1, -1);
    issue(15, 0, 1, 14);
    tb_check("abort_final", int'(bus.q), 15);

    // Handshake: a second command held valid through a RUN to 12.
    bus.cmd_target = 4'd12;
    bus.cmd_bounce = 1'b0;
    bus.cmd_passes = 4'd1;
    bus.cmd_valid  = 1'b1;
    n = 0;
    do begin step_cycle(); n++; end while (m_acc == 0 && n < 200);
    bus.cmd_target = 4'd1;
    n = 0;
    do begin step_cycle(); n++; end while (m_acc == 0 && n < 200);
    if (n >= 200) tb_check("held_accept_timeout", 0, 1);
    tb_check("held_accept_from", int'(bus.q), 12);
    bus.cmd_valid = 1'b0;
    drain(-1);
    tb_check("held_final", int'(bus.q), 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus.cmd_valid  = 1'($urandom_range(0, 1));
      bus.cmd_target = 4'($urandom_range(0, 15));
      bus.cmd_bounce = 1'($urandom_range(0, 1));
      bus.cmd_passes = 4'($urandom_range(0, 3));
      bus.abort      = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      step_cycle();
    end
    bus.cmd_valid = 1'b0;
    bus.abort = 1'b0;
    drain(-1);

    // Asynchronous reset mid-RUN at q = 6.
    issue(0, 0, 1, -1);
    bus.cmd_target = 4'd15;
    bus.cmd_bounce = 1'b0;
    bus.cmd_valid  = 1'b1;
    n = 0;
    do begin step_cycle(); n++; end while (m_acc == 0 && n < 200);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (m_q != 6 && n < 200) begin step_cycle(); n++; end
    if (n >= 200) tb_check("reach6_timeout", 0, 1);
    #3;
    clear_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    clear_n = 1'b1;
    step_cycle();
    step_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
